// File: rtl/proto245a_device.sv
// proto245a_device: FT245-style FIFO chip model answering RD#/WR# strobes from an FPGA master.
// Define PROTO245A_DEVICE_PROT_CHECK_EN to build the sticky protocol checker behind prot_err.
module proto245a_device #(
   parameter int DATA_W         = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int RECOVERY_TICKS = 4
) (
   input  logic                         ft_clk,
   input  logic                         ft_rstn,
   input  logic                         ft_rdn,
   input  logic                         ft_wrn,
   input  logic [DATA_W-1:0]            ft_din,
   output logic [DATA_W-1:0]            ft_dout,
   output logic                         ft_dout_oe,
   output logic                         ft_rxfn,
   output logic                         ft_txen,
   input  logic [DATA_W-1:0]            h2f_wdata,
   input  logic                         h2f_wr,
   output logic                         h2f_full,
   input  logic                         f2h_rd,
   output logic [DATA_W-1:0]            f2h_rdata,
   output logic                         f2h_rvalid,
   output logic                         f2h_empty,
   output logic [$clog2(FIFO_DEPTH):0]  h2f_count,
   output logic [$clog2(FIFO_DEPTH):0]  f2h_count,
   output logic [3:0]                   prot_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = (RECOVERY_TICKS > 1) ? $clog2(RECOVERY_TICKS) : 1;
   localparam logic [RW-1:0] REC_LOAD = RW'(RECOVERY_TICKS - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RD_ACT = 3'd1;
   localparam logic [2:0] ST_RD_REC = 3'd2;
   localparam logic [2:0] ST_WR_ACT = 3'd3;
   localparam logic [2:0] ST_WR_REC = 3'd4;

   logic [SYNC_STAGES-1:0] rdn_sync, wrn_sync;
   logic                   rdn_s, wrn_s;
   logic [DATA_W-1:0]      din_r, wr_hold;
   logic [DATA_W-1:0]      h2f_mem [FIFO_DEPTH];
   logic [DATA_W-1:0]      f2h_mem [FIFO_DEPTH];
   logic [CW-1:0]          h2f_wp, h2f_rp, f2h_wp, f2h_rp;
   logic [CW-1:0]          h2f_cnt_nxt, f2h_cnt_nxt;
   logic                   h2f_empty, f2h_full;
   logic                   h2f_push, h2f_pop, f2h_push, f2h_pop;
   logic [2:0]             state, state_nxt;
   logic [RW-1:0]          rec_cnt, rec_nxt;

   // Strobes are asynchronous to ft_clk; synchronizers idle high like the strobes.
   always_ff @(posedge ft_clk or negedge ft_rstn) begin
      if (!ft_rstn) begin
         rdn_sync <= '1;
         wrn_sync <= '1;
      end else begin
         rdn_sync <= {rdn_sync[SYNC_STAGES-2:0], ft_rdn};
         wrn_sync <= {wrn_sync[SYNC_STAGES-2:0], ft_wrn};
      end
   end

   assign rdn_s = rdn_sync[SYNC_STAGES-1];
   assign wrn_s = wrn_sync[SYNC_STAGES-1];

   assign h2f_count   = h2f_wp - h2f_rp;
   assign f2h_count   = f2h_wp - f2h_rp;
   assign h2f_full    = (h2f_count == DEPTH_C);
   assign h2f_empty   = (h2f_count == '0);
   assign f2h_full    = (f2h_count == DEPTH_C);
   assign f2h_empty   = (f2h_count == '0);

   // A host push into a full h2f is only legal when the device pops in the same cycle.
   assign h2f_push    = h2f_wr & (~h2f_full | h2f_pop);
   assign f2h_pop     = f2h_rd & ~f2h_empty;
   assign h2f_cnt_nxt = h2f_count + CW'(h2f_push) - CW'(h2f_pop);
   assign f2h_cnt_nxt = f2h_count + CW'(f2h_push) - CW'(f2h_pop);

   always_comb begin
      state_nxt = state;
      rec_nxt   = rec_cnt;
      h2f_pop   = 1'b0;
      f2h_push  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rdn_s && !h2f_empty)
               state_nxt = ST_RD_ACT;
            else if (!wrn_s && !f2h_full)
               state_nxt = ST_WR_ACT;
         end
         ST_RD_ACT: begin
            if (rdn_s) begin
               h2f_pop   = 1'b1;
               rec_nxt   = REC_LOAD;
               state_nxt = ST_RD_REC;
            end
         end
         ST_WR_ACT: begin
            if (wrn_s) begin
               f2h_push  = 1'b1;
               rec_nxt   = REC_LOAD;
               state_nxt = ST_WR_REC;
            end
         end
         ST_RD_REC, ST_WR_REC: begin
            if (rec_cnt == '0)
               state_nxt = ST_IDLE;
            else
               rec_nxt = rec_cnt - 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Buffer storage and write holding register carry no reset.
   always_ff @(posedge ft_clk) begin
      din_r <= ft_din;
      if (h2f_push)
         h2f_mem[h2f_wp[AW-1:0]] <= h2f_wdata;
      if (f2h_push)
         f2h_mem[f2h_wp[AW-1:0]] <= wr_hold;
      if ((state == ST_IDLE && state_nxt == ST_WR_ACT) || (state == ST_WR_ACT && !wrn_s))
         wr_hold <= din_r;
   end

   always_ff @(posedge ft_clk or negedge ft_rstn) begin
      if (!ft_rstn) begin
         state      <= ST_IDLE;
         rec_cnt    <= '0;
         h2f_wp     <= '0;
         h2f_rp     <= '0;
         f2h_wp     <= '0;
         f2h_rp     <= '0;
         ft_dout    <= '0;
         ft_dout_oe <= 1'b0;
         ft_rxfn    <= 1'b1;
         ft_txen    <= 1'b0;
         f2h_rdata  <= '0;
         f2h_rvalid <= 1'b0;
      end else begin
         state   <= state_nxt;
         rec_cnt <= rec_nxt;
         if (h2f_push) h2f_wp <= h2f_wp + 1'b1;
         if (h2f_pop)  h2f_rp <= h2f_rp + 1'b1;
         if (f2h_push) f2h_wp <= f2h_wp + 1'b1;
         if (f2h_pop)  f2h_rp <= f2h_rp + 1'b1;
         if (state == ST_IDLE && state_nxt == ST_RD_ACT) begin
            ft_dout    <= h2f_mem[h2f_rp[AW-1:0]];
            ft_dout_oe <= 1'b1;
         end else if (h2f_pop) begin
            ft_dout_oe <= 1'b0;
         end
         f2h_rvalid <= f2h_pop;
         if (f2h_pop)
            f2h_rdata <= f2h_mem[f2h_rp[AW-1:0]];
         ft_rxfn <= (h2f_cnt_nxt == '0) | (state_nxt == ST_RD_REC);
         ft_txen <= (f2h_cnt_nxt == DEPTH_C) | (state_nxt == ST_WR_REC);
      end
   end

`ifdef PROTO245A_DEVICE_PROT_CHECK_EN
   // hist[0] is last cycle's strobe, hist[1] the one before; 2'b10 then high means a 1-cycle pulse.
   logic [1:0] rd_hist, wr_hist;

   always_ff @(posedge ft_clk or negedge ft_rstn) begin
      if (!ft_rstn) begin
         prot_err <= '0;
         rd_hist  <= 2'b11;
         wr_hist  <= 2'b11;
      end else begin
         rd_hist <= {rd_hist[0], rdn_s};
         wr_hist <= {wr_hist[0], wrn_s};
         if (!rdn_s && !wrn_s)
            prot_err[0] <= 1'b1;
         if (state == ST_IDLE && !rdn_s && ft_rxfn)
            prot_err[1] <= 1'b1;
         if (state == ST_IDLE && !wrn_s && ft_txen)
            prot_err[2] <= 1'b1;
         if ((rdn_s && rd_hist == 2'b10) || (wrn_s && wr_hist == 2'b10))
            prot_err[3] <= 1'b1;
      end
   end
`else
   assign prot_err = '0;
`endif

endmodule

// File: tb/tb_proto245a_device.sv
// Bench for proto245a_device: vector table, corner-case sequences and a randomized queue-model phase.
module tb_proto245a_device;
   localparam int DATA_W         = 8;
   localparam int FIFO_DEPTH     = 16;
   localparam int SYNC_STAGES    = 2;
   localparam int RECOVERY_TICKS = 4;
   localparam int CW             = $clog2(FIFO_DEPTH) + 1;
   localparam int LAT            = SYNC_STAGES + 1;
`ifdef PROTO245A_DEVICE_PROT_CHECK_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   localparam logic [1:0] OP_PUSH  = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [1:0] OP_POP   = 2'd3;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] data;
      logic [4:0] exp_h2f;
      logic [4:0] exp_f2h;
   } vec_t;

   logic              ft_clk, ft_rstn, ft_rdn, ft_wrn;
   logic [DATA_W-1:0] ft_din, ft_dout, h2f_wdata, f2h_rdata;
   logic              ft_dout_oe, ft_rxfn, ft_txen;
   logic              h2f_wr, h2f_full, f2h_rd, f2h_rvalid, f2h_empty;
   logic [CW-1:0]     h2f_count, f2h_count;
   logic [3:0]        prot_err;

   proto245a_device #(
      .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
      .SYNC_STAGES(SYNC_STAGES), .RECOVERY_TICKS(RECOVERY_TICKS)
   ) dut (
      .ft_clk(ft_clk), .ft_rstn(ft_rstn), .ft_rdn(ft_rdn), .ft_wrn(ft_wrn),
      .ft_din(ft_din), .ft_dout(ft_dout), .ft_dout_oe(ft_dout_oe),
      .ft_rxfn(ft_rxfn), .ft_txen(ft_txen),
      .h2f_wdata(h2f_wdata), .h2f_wr(h2f_wr), .h2f_full(h2f_full),
      .f2h_rd(f2h_rd), .f2h_rdata(f2h_rdata), .f2h_rvalid(f2h_rvalid),
      .f2h_empty(f2h_empty), .h2f_count(h2f_count), .f2h_count(f2h_count),
      .prot_err(prot_err)
   );

   initial ft_clk = 1'b0;
   always #5 ft_clk = ~ft_clk;

   int checks = 0;
   int errors = 0;
   logic [7:0] hq[$];
   logic [7:0] fq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge ft_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      ft_rstn = 1'b0; ft_rdn = 1'b1; ft_wrn = 1'b1; ft_din = '0;
      h2f_wr = 1'b0; h2f_wdata = '0; f2h_rd = 1'b0;
      hq.delete(); fq.delete();
      tick(3);
      ft_rstn = 1'b1;
      tick(2);
   endtask

   task automatic host_push(input logic [7:0] d);
      h2f_wdata = d;
      h2f_wr    = 1'b1;
      tick(1);
      h2f_wr    = 1'b0;
   endtask

   task automatic host_pop(output logic [7:0] d, output logic v);
      f2h_rd = 1'b1;
      tick(1);
      v = f2h_rvalid;
      d = f2h_rdata;
      f2h_rd = 1'b0;
      tick(1);
      check("rvalid_single_pulse", f2h_rvalid, 0);
   endtask

   // RD# low 8 cycles; reports data seen, fall->oe latency, rise->RXF# latency and RXF# high run.
   task automatic master_read(output logic [7:0] d, output int oe_lat, output int rise_lat, output int hi_len);
      bit ended;
      oe_lat = -1; rise_lat = -1; hi_len = 0; ended = 0;
      ft_rdn = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         if (ft_dout_oe && oe_lat < 0) oe_lat = k;
      end
      d = ft_dout;
      ft_rdn = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         if (ft_rxfn && !ended) begin
            if (rise_lat < 0) rise_lat = k;
            hi_len++;
         end else if (rise_lat >= 0) begin
            ended = 1;
         end
      end
      check("oe_off_after_read", ft_dout_oe, 0);
   endtask

   task automatic master_write(input logic [7:0] d, output int rise_lat, output int hi_len);
      bit ended;
      rise_lat = -1; hi_len = 0; ended = 0;
      ft_din = d;
      ft_wrn = 1'b0;
      tick(6);
      ft_wrn = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         if (ft_txen && !ended) begin
            if (rise_lat < 0) rise_lat = k;
            hi_len++;
         end else if (rise_lat >= 0) begin
            ended = 1;
         end
      end
      ft_din = ~d;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_h2f_count"}, h2f_count, hq.size());
      check({tag, "_f2h_count"}, f2h_count, fq.size());
      check({tag, "_rxfn"}, ft_rxfn, hq.size() == 0);
      check({tag, "_txen"}, ft_txen, fq.size() == FIFO_DEPTH);
      check({tag, "_h2f_full"}, h2f_full, hq.size() == FIFO_DEPTH);
      check({tag, "_f2h_empty"}, f2h_empty, fq.size() == 0);
   endtask

   initial begin
      vec_t vecs[10];
      logic [7:0] d, exp_d;
      logic v;
      int oe_lat, rise_lat, hi_len;

      vecs[0] = '{OP_PUSH,  8'hA5, 5'd1, 5'd0};
      vecs[1] = '{OP_PUSH,  8'h3C, 5'd2, 5'd0};
      vecs[2] = '{OP_READ,  8'hA5, 5'd1, 5'd0};
      vecs[3] = '{OP_READ,  8'h3C, 5'd0, 5'd0};
      vecs[4] = '{OP_WRITE, 8'h5A, 5'd0, 5'd1};
      vecs[5] = '{OP_POP,   8'h5A, 5'd0, 5'd0};
      vecs[6] = '{OP_WRITE, 8'hC3, 5'd0, 5'd1};
      vecs[7] = '{OP_PUSH,  8'h7E, 5'd1, 5'd1};
      vecs[8] = '{OP_READ,  8'h7E, 5'd0, 5'd1};
      vecs[9] = '{OP_POP,   8'hC3, 5'd0, 5'd0};

      // Reset state
      do_reset();
      tick(10);
      check("rst_rxfn", ft_rxfn, 1);
      check("rst_txen", ft_txen, 0);
      check("rst_oe", ft_dout_oe, 0);
      check("rst_dout", ft_dout, 0);
      check("rst_h2f_count", h2f_count, 0);
      check("rst_f2h_count", f2h_count, 0);
      check("rst_rvalid", f2h_rvalid, 0);
      check("rst_rdata", f2h_rdata, 0);
      check("rst_prot_err", prot_err, 0);
      check("rst_f2h_empty", f2h_empty, 1);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         case (vecs[i].op)
            OP_PUSH: host_push(vecs[i].data);
            OP_READ: begin
               master_read(d, oe_lat, rise_lat, hi_len);
               check("vec_read_data", d, vecs[i].data);
               check("vec_read_oe_lat", oe_lat, LAT);
               check("vec_read_rxf_lat", rise_lat, LAT);
               check("vec_read_rxf_hi", hi_len, (vecs[i].exp_h2f == 0) ? 10 : RECOVERY_TICKS);
            end
            OP_WRITE: begin
               master_write(vecs[i].data, rise_lat, hi_len);
               check("vec_write_txe_lat", rise_lat, LAT);
               check("vec_write_txe_hi", hi_len, RECOVERY_TICKS);
            end
            default: begin
               host_pop(d, v);
               check("vec_pop_rvalid", v, 1);
               check("vec_pop_data", d, vecs[i].data);
            end
         endcase
         check("vec_h2f_count", h2f_count, vecs[i].exp_h2f);
         check("vec_f2h_count", f2h_count, vecs[i].exp_f2h);
         check("vec_rxfn", ft_rxfn, vecs[i].exp_h2f == 0);
         check("vec_txen", ft_txen, vecs[i].exp_f2h == FIFO_DEPTH);
      end

      // Fill f2h, then a write while TXE# is inactive
      do_reset();
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         d = 8'($urandom);
         master_write(d, rise_lat, hi_len);
         fq.push_back(d);
      end
      check_model("f2h_full");
      master_write(8'hEE, rise_lat, hi_len);
      check("ovf_f2h_count", f2h_count, FIFO_DEPTH);
      check("ovf_prot_err", prot_err, PROT_EN ? 4'b0100 : 4'b0000);
      host_pop(d, v);
      exp_d = fq.pop_front();
      check("ovf_pop_data", d, exp_d);
      tick(2);
      check("ovf_txen_after_pop", ft_txen, 0);
      while (fq.size() > 0) begin
         host_pop(d, v);
         exp_d = fq.pop_front();
         check("drain_pop_data", d, exp_d);
      end
      host_pop(d, v);
      check("empty_pop_no_rvalid", v, 0);
      check_model("f2h_drained");

      // Both strobes fall together: read wins
      do_reset();
      host_push(8'h11);
      ft_din = 8'h99;
      ft_rdn = 1'b0;
      ft_wrn = 1'b0;
      tick(8);
      check("both_oe", ft_dout_oe, 1);
      check("both_dout", ft_dout, 8'h11);
      ft_rdn = 1'b1;
      ft_wrn = 1'b1;
      tick(12);
      check("both_f2h_count", f2h_count, 0);
      check("both_h2f_count", h2f_count, 0);
      check("both_prot_err", prot_err, PROT_EN ? 4'b0001 : 4'b0000);

      // h2f full: push ignored alone, accepted with a simultaneous device pop
      do_reset();
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         d = 8'($urandom);
         host_push(d);
         hq.push_back(d);
      end
      host_push(8'hFF);
      check_model("h2f_full");
      ft_rdn = 1'b0;
      tick(8);
      check("fullrd_dout", ft_dout, hq[0]);
      ft_rdn = 1'b1;
      tick(SYNC_STAGES);
      h2f_wdata = 8'hB7;
      h2f_wr    = 1'b1;
      tick(1);
      h2f_wr    = 1'b0;
      void'(hq.pop_front());
      hq.push_back(8'hB7);
      check("fullrd_h2f_count", h2f_count, FIFO_DEPTH);
      tick(8);
      check_model("fullrd_after");
      while (hq.size() > 0) begin
         master_read(d, oe_lat, rise_lat, hi_len);
         exp_d = hq.pop_front();
         check("fullrd_drain_data", d, exp_d);
      end
      check_model("fullrd_drained");

      // Reset asserted during RD_ACT
      do_reset();
      host_push(8'h42);
      ft_rdn = 1'b0;
      tick(LAT + 1);
      check("midrst_oe_before", ft_dout_oe, 1);
      ft_rstn = 1'b0;
      #1;
      check("midrst_oe_async", ft_dout_oe, 0);
      check("midrst_h2f_count", h2f_count, 0);
      check("midrst_rxfn", ft_rxfn, 1);
      ft_rdn = 1'b1;
      tick(3);
      ft_rstn = 1'b1;
      tick(2);
      check("midrst_oe_after", ft_dout_oe, 0);
      host_push(8'h24);
      master_read(d, oe_lat, rise_lat, hi_len);
      check("midrst_next_read", d, 8'h24);
      check("midrst_next_oe_lat", oe_lat, LAT);

      // Randomized mix against queue model
      do_reset();
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0: begin
               d = 8'($urandom);
               host_push(d);
               if (hq.size() < FIFO_DEPTH) hq.push_back(d);
            end
            1: begin
               if (hq.size() > 0) begin
                  master_read(d, oe_lat, rise_lat, hi_len);
                  exp_d = hq.pop_front();
                  check("rnd_read_data", d, exp_d);
               end else begin
                  tick(1);
               end
            end
            2: begin
               if (fq.size() < FIFO_DEPTH) begin
                  d = 8'($urandom);
                  master_write(d, rise_lat, hi_len);
                  fq.push_back(d);
               end else begin
                  tick(1);
               end
            end
            default: begin
               host_pop(d, v);
               if (fq.size() > 0) begin
                  exp_d = fq.pop_front();
                  check("rnd_pop_rvalid", v, 1);
                  check("rnd_pop_data", d, exp_d);
               end else begin
                  check("rnd_pop_empty_rvalid", v, 0);
               end
            end
         endcase
         check_model("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
